// File: rtl/d5m_config_sequencer.sv
// D5M sensor configuration sequencer: replays a register ROM through an I2C write
// master after power-up settling, retries NACKed writes and services exposure updates.
module d5m_config_sequencer #(
  parameter int unsigned TABLE_LEN      = 20,
  parameter int unsigned STARTUP_CYCLES = 50000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  EXPOSURE_REG   = 8'h09
) (
  input  logic        piul1FpgaClock,
  input  logic        piul1FpgaReset,
  input  logic        piul1Start,
  input  logic        piul1ExposureUpdate,
  input  logic [15:0] piul16Exposure,
  output logic [4:0]  poul5TableIndex,
  input  logic [23:0] piul24TableData,
  output logic        poul1WrReq,
  output logic [7:0]  poul8WrAddr,
  output logic [15:0] poul16WrData,
  input  logic        piul1WrDone,
  input  logic        piul1WrNack,
  output logic        poul1Busy,
  output logic        poul1ConfigDone,
  output logic        poul1Error
);

  localparam int unsigned RetryW = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;
  localparam int unsigned StartW = ($clog2(STARTUP_CYCLES + 1) > 1) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam int unsigned IndexW = 5;

  typedef enum logic [2:0] {
    IDLE, WAIT_PWR, LOAD, REQ, WAIT_ACK, GAP, DONE, ERROR
  } stateT;

  stateT             state;
  logic [StartW-1:0] startCnt;
  logic [RetryW-1:0] retryCnt;
  logic              expoPending;
  logic              expoActive;

  always_ff @(posedge piul1FpgaClock) begin
    if (piul1FpgaReset) begin
      state           <= IDLE;
      startCnt        <= '0;
      retryCnt        <= '0;
      expoPending     <= 1'b0;
      expoActive      <= 1'b0;
      poul5TableIndex <= '0;
      poul1WrReq      <= 1'b0;
      poul8WrAddr     <= '0;
      poul16WrData    <= '0;
      poul1Busy       <= 1'b0;
      poul1ConfigDone <= 1'b0;
      poul1Error      <= 1'b0;
    end else begin
      // Exposure requests arriving mid-pass are remembered and collapse into one write
      if (piul1ExposureUpdate && poul1Busy) begin
        expoPending <= 1'b1;
      end

      case (state)
        IDLE, DONE, ERROR: begin
          if (piul1Start) begin
            state           <= WAIT_PWR;
            poul1Busy       <= 1'b1;
            poul5TableIndex <= '0;
            retryCnt        <= '0;
            startCnt        <= '0;
            poul1ConfigDone <= 1'b0;
            poul1Error      <= 1'b0;
            expoPending     <= 1'b0;
            expoActive      <= 1'b0;
          end else if (state == DONE && (expoPending || piul1ExposureUpdate)) begin
            poul8WrAddr  <= EXPOSURE_REG;
            poul16WrData <= piul16Exposure;
            expoPending  <= 1'b0;
            expoActive   <= 1'b1;
            poul1WrReq   <= 1'b1;
            poul1Busy    <= 1'b1;
            state        <= REQ;
          end else if (state != DONE) begin
            expoPending <= 1'b0;
          end
        end

        WAIT_PWR: begin
          if (startCnt == StartW'(STARTUP_CYCLES - 1)) begin
            state <= LOAD;
          end else begin
            startCnt <= startCnt + StartW'(1);
          end
        end

        LOAD: begin
          poul8WrAddr  <= piul24TableData[23:16];
          poul16WrData <= piul24TableData[15:0];
          poul1WrReq   <= 1'b1;
          state        <= REQ;
        end

        REQ: begin
          state <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (piul1WrDone) begin
            poul1WrReq <= 1'b0;
            if (!piul1WrNack) begin
              retryCnt <= '0;
              if (expoActive) begin
                expoActive <= 1'b0;
                poul1Busy  <= 1'b0;
                state      <= DONE;
              end else if (poul5TableIndex == IndexW'(TABLE_LEN - 1)) begin
                poul1ConfigDone <= 1'b1;
                poul1Busy       <= 1'b0;
                state           <= DONE;
              end else begin
                poul5TableIndex <= poul5TableIndex + IndexW'(1);
                state           <= LOAD;
              end
            end else if (retryCnt < RetryW'(MAX_RETRY)) begin
              retryCnt <= retryCnt + RetryW'(1);
              state    <= GAP;
            end else begin
              // Index is left on the failing entry for diagnosis
              poul1Error <= 1'b1;
              poul1Busy  <= 1'b0;
              expoActive <= 1'b0;
              state      <= ERROR;
            end
          end
        end

        GAP: begin
          poul1WrReq <= 1'b1;
          state      <= REQ;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d5m_config_sequencer.sv
// Bench for d5m_config_sequencer: scripted I2C master with NACK plans, ROM model and
// an expected-write-list reference derived from per-entry NACK counts.
`timescale 1ns/1ps
module tb_d5m_config_sequencer;

  localparam int unsigned TableLen      = 4;
  localparam int unsigned StartupCycles = 10;
  localparam int unsigned MaxRetry      = 3;
  localparam logic [7:0]  ExpoReg       = 8'h09;

  logic        clk;
  logic        rst;
  logic        start;
  logic        expoUpd;
  logic [15:0] expo;
  logic [4:0]  tableIndex;
  logic [23:0] tableData;
  logic        wrReq;
  logic [7:0]  wrAddr;
  logic [15:0] wrData;
  logic        wrDone;
  logic        wrNack;
  logic        busy;
  logic        configDone;
  logic        error;

  logic        mDone;
  logic        mNack;
  logic        lateDone;
  logic        lateNack;
  bit          masterEn;
  int          ackDelay;

  logic [23:0] rom [32];
  bit          nackQ[$];
  logic [23:0] reqLog[$];
  int          gapLog[$];
  logic [23:0] expQ[$];
  int          nk [TableLen];

  int checks;
  int failures;

  d5m_config_sequencer #(
    .TABLE_LEN(TableLen),
    .STARTUP_CYCLES(StartupCycles),
    .MAX_RETRY(MaxRetry),
    .EXPOSURE_REG(ExpoReg)
  ) dut (
    .piul1FpgaClock(clk),
    .piul1FpgaReset(rst),
    .piul1Start(start),
    .piul1ExposureUpdate(expoUpd),
    .piul16Exposure(expo),
    .poul5TableIndex(tableIndex),
    .piul24TableData(tableData),
    .poul1WrReq(wrReq),
    .poul8WrAddr(wrAddr),
    .poul16WrData(wrData),
    .piul1WrDone(wrDone),
    .piul1WrNack(wrNack),
    .poul1Busy(busy),
    .poul1ConfigDone(configDone),
    .poul1Error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tableData = rom[tableIndex];
  assign wrDone    = masterEn ? mDone : lateDone;
  assign wrNack    = masterEn ? mNack : lateNack;

  // I2C master model: logs each request, answers after ackDelay cycles from the NACK plan
  initial begin : master
    int  cnt;
    bit  active;
    int  lowRun;
    cnt = 0; active = 1'b0; lowRun = 0;
    mDone = 1'b0; mNack = 1'b0;
    forever begin
      @(posedge clk); #1;
      mDone = 1'b0;
      mNack = 1'b0;
      if (!masterEn) begin
        active = 1'b0;
        lowRun = 0;
      end else if (!wrReq) begin
        active = 1'b0;
        lowRun++;
      end else if (!active) begin
        active = 1'b1;
        cnt    = 1;
        reqLog.push_back({wrAddr, wrData});
        gapLog.push_back(lowRun);
        lowRun = 0;
      end else begin
        cnt++;
        if (cnt == ackDelay) begin
          mDone = 1'b1;
          mNack = (nackQ.size() > 0) ? nackQ.pop_front() : 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randRom();
    for (int i = 0; i < int'(TableLen); i++) rom[i] = 24'($urandom);
  endtask

  // Clears the logs and turns per-entry NACK counts into the master's answer sequence
  task automatic prepare();
    reqLog.delete();
    gapLog.delete();
    nackQ.delete();
    for (int i = 0; i < int'(TableLen); i++) begin
      for (int r = 0; r < nk[i] && r <= int'(MaxRetry); r++) nackQ.push_back(1'b1);
      if (nk[i] > int'(MaxRetry)) return;
      nackQ.push_back(1'b0);
    end
  endtask

  // Reference: each entry is requested once per NACK plus once for the ack, capped at
  // MaxRetry+1 attempts, after which the pass stops; exposure write only on success
  task automatic buildExp(input bit expoOn, input logic [15:0] val, output int errIdx);
    int n;
    expQ.delete();
    errIdx = -1;
    for (int i = 0; i < int'(TableLen); i++) begin
      n = (nk[i] > int'(MaxRetry)) ? int'(MaxRetry) + 1 : nk[i] + 1;
      for (int r = 0; r < n; r++) expQ.push_back(rom[i]);
      if (nk[i] > int'(MaxRetry)) begin
        errIdx = i;
        break;
      end
    end
    if (errIdx < 0 && expoOn) expQ.push_back({ExpoReg, val});
  endtask

  task automatic waitIdle(input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 3000) begin
      tick();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk({tag, "_timeout"}, 32'(n < 3000), 32'(1));
  endtask

  task automatic checkEnd(input string tag, input int errIdx);
    int m;
    chk({tag, "_nwrites"}, 32'(reqLog.size()), 32'(expQ.size()));
    m = (reqLog.size() < expQ.size()) ? reqLog.size() : expQ.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_wr%0d", tag, i), 32'(reqLog[i]), 32'(expQ[i]));
    chk({tag, "_configDone"}, 32'(configDone), 32'(errIdx < 0));
    chk({tag, "_error"}, 32'(error), 32'(errIdx >= 0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_index"}, 32'(tableIndex), (errIdx < 0) ? 32'(TableLen - 1) : 32'(errIdx));
  endtask

  task automatic pulseStart(input bit withExpo, input logic [15:0] val);
    start = 1'b1;
    if (withExpo) begin
      expo    = val;
      expoUpd = 1'b1;
    end
    tick();
    start   = 1'b0;
    expoUpd = 1'b0;
  endtask

  initial begin : main
    int k;
    int err;
    bit expoOn;
    logic [15:0] expoVal;

    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; expoUpd = 1'b0; expo = '0;
    lateDone = 1'b0; lateNack = 1'b0; masterEn = 1'b1; ackDelay = 5;
    for (int i = 0; i < 32; i++) rom[i] = '0;
    for (int i = 0; i < int'(TableLen); i++) nk[i] = 0;

    repeat (3) tick();
    chk("rst_wrReq", 32'(wrReq), 32'(0));
    chk("rst_wrAddr", 32'(wrAddr), 32'(0));
    chk("rst_wrData", 32'(wrData), 32'(0));
    chk("rst_index", 32'(tableIndex), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_configDone", 32'(configDone), 32'(0));
    chk("rst_error", 32'(error), 32'(0));
    rst = 1'b0;
    repeat (8) tick();
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_wrReq", 32'(wrReq), 32'(0));

    // Clean full pass with fixed 5-cycle acks
    randRom();
    prepare();
    pulseStart(1'b0, '0);
    chk("pass_busy_next", 32'(busy), 32'(1));
    k = 1;
    while (!wrReq && k < 100) begin
      tick();
      k++;
    end
    chk("pass_first_req_latency", 32'(k), 32'(12));
    waitIdle("pass");
    buildExp(1'b0, '0, err);
    checkEnd("pass", err);

    // Entry 2 NACKed twice then acked
    randRom();
    nk[2] = 2;
    prepare();
    pulseStart(1'b0, '0);
    waitIdle("retry");
    buildExp(1'b0, '0, err);
    checkEnd("retry", err);
    if (gapLog.size() >= 5) begin
      chk("retry_gap1", 32'(gapLog[3]), 32'(1));
      chk("retry_gap2", 32'(gapLog[4]), 32'(1));
    end else begin
      chk("retry_gap_count", 32'(gapLog.size()), 32'(5));
    end
    nk[2] = 0;

    // Entry 1 NACKed beyond the retry budget, then a clean restart
    randRom();
    nk[1] = 4;
    prepare();
    pulseStart(1'b0, '0);
    waitIdle("err");
    buildExp(1'b0, '0, err);
    checkEnd("err", err);
    nk[1] = 0;
    prepare();
    pulseStart(1'b0, '0);
    chk("restart_index", 32'(tableIndex), 32'(0));
    chk("restart_error_clr", 32'(error), 32'(0));
    waitIdle("restart");
    buildExp(1'b0, '0, err);
    checkEnd("restart", err);

    // Exposure request while working on entry 1 is deferred to the end of the pass
    randRom();
    prepare();
    pulseStart(1'b0, '0);
    k = 0;
    while (tableIndex != 5'd1 && k < 500) begin
      tick();
      k++;
    end
    chk("expo_reach_idx1", 32'(k < 500), 32'(1));
    expo = 16'h0400;
    expoUpd = 1'b1;
    tick();
    expoUpd = 1'b0;
    waitIdle("expo");
    buildExp(1'b1, 16'h0400, err);
    checkEnd("expo", err);

    // Start and exposure together in DONE: start wins
    randRom();
    prepare();
    pulseStart(1'b1, 16'hBEEF);
    waitIdle("prio");
    buildExp(1'b0, '0, err);
    checkEnd("prio", err);

    // Reset in the middle of a write, followed by a stray completion
    ackDelay = 20;
    prepare();
    pulseStart(1'b0, '0);
    k = 0;
    while (!wrReq && k < 100) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("rstmid_in_ack", 32'(wrReq), 32'(1));
    masterEn = 1'b0;
    rst = 1'b1;
    tick();
    chk("rstmid_wrReq", 32'(wrReq), 32'(0));
    chk("rstmid_busy", 32'(busy), 32'(0));
    chk("rstmid_wrAddr", 32'(wrAddr), 32'(0));
    chk("rstmid_wrData", 32'(wrData), 32'(0));
    rst = 1'b0;
    tick();
    lateDone = 1'b1;
    tick();
    lateDone = 1'b0;
    repeat (4) tick();
    chk("late_busy", 32'(busy), 32'(0));
    chk("late_wrReq", 32'(wrReq), 32'(0));
    chk("late_index", 32'(tableIndex), 32'(0));
    chk("late_configDone", 32'(configDone), 32'(0));
    chk("late_error", 32'(error), 32'(0));
    masterEn = 1'b1;

    // Randomized passes: random ROM, ack latency, NACK counts and exposure requests
    for (int it = 0; it < 10; it++) begin
      randRom();
      ackDelay = $urandom_range(2, 7);
      for (int i = 0; i < int'(TableLen); i++)
        nk[i] = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
      expoOn  = 1'($urandom_range(0, 1));
      expoVal = 16'($urandom);
      prepare();
      pulseStart(1'b0, '0);
      if (expoOn) begin
        k = 0;
        while (reqLog.size() == 0 && k < 500) begin
          tick();
          k++;
        end
        expo = expoVal;
        expoUpd = 1'b1;
        tick();
        expoUpd = 1'b0;
      end
      waitIdle($sformatf("rnd%0d", it));
      buildExp(expoOn, expoVal, err);
      checkEnd($sformatf("rnd%0d", it), err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
